steer_en_dp: RTL
================

Name: steer_en_dp

Overview:
- Datapath stage directly upstream of the steering-enable state machine.
- Filters left/right load-cell readings from the A2D interface with a 4-sample moving average per side.
- Produces the registered weight and balance flags the state machine consumes: sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16.
- Owns the 1.3 s rider-settle timer (tmr_full / clr_tmr).

Parameters:
- fast_sim, 1'b0: when 1, timer terminal count shrinks to 32767 for simulation.
- MIN_RIDER_WEIGHT, 12'h200: minimum rider weight threshold on the averaged load sum.
- HYSTERESIS, 12'h040: half-width of the weight hysteresis band.

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- vld  in  1  one-clock strobe: lft_ld/rght_ld hold a new valid reading.
- lft_ld  in  12  left load-cell reading, unsigned.
- rght_ld  in  12  right load-cell reading, unsigned.
- clr_tmr  in  1  synchronous timer clear from the state machine.
- tmr_full  out  1  settle timer has reached terminal count.
- sum_gt_min  out  1  averaged sum > MIN_RIDER_WEIGHT + HYSTERESIS.
- sum_lt_min  out  1  averaged sum < MIN_RIDER_WEIGHT - HYSTERESIS.
- diff_gt_eigth  out  1  |left-right| > sum/8.
- diff_gt_15_16  out  1  |left-right| > sum - sum/16.

Behaviour:
- Reset/clock: reset rst_n, asynchronous, active-low; clock clk. All state is in flops on posedge clk.
- Reset values: all history registers 0, timer count 0, tmr_full 0, sum_gt_min 0, sum_lt_min 1, diff_gt_eigth 0, diff_gt_15_16 0. These flag values equal the combinational result for all-zero history.
- History: two 4-entry shift registers, one per side.
  - On a clock edge with vld=1, each shifts in its current input and drops its oldest entry.
  - With vld=0, history holds.
  - No warm-up masking: the first three readings after reset average against zeros.
- Averaging:
  - lft_avg = (sum of 4 left entries, 14-bit) >> 2, 12-bit, truncating. rght_avg is computed the same way.
  - sum = lft_avg + rght_avg, 13-bit, no overflow.
  - diff = |lft_avg - rght_avg|, 12-bit unsigned.
- Flags:
  - sum_gt_min = sum > (MIN_RIDER_WEIGHT + HYSTERESIS).
  - sum_lt_min = sum < (MIN_RIDER_WEIGHT - HYSTERESIS).
  - diff_gt_eigth = diff > (sum >> 3).
  - diff_gt_15_16 = diff > (sum - (sum >> 4)).
  - All comparisons are unsigned, 13-bit, strict. Equality yields 0.
  - sum_gt_min and sum_lt_min are never both 1. Both are 0 inside the hysteresis band.
- Latency:
  - Flags are registered every clock from the current history.
  - A reading sampled at edge k (vld=1) is reflected in the flags after edge k+1.
  - Flags stay stable while vld is low.
- Timer:
  - 26-bit counter cnt. TC = fast_sim ? 32767 : 64,999,999 (1.3 s at 50 MHz).
  - Per edge, priority order:
    1. clr_tmr=1 → cnt=0.
    2. Else if cnt<TC → cnt+1.
    3. Else hold (saturate, no wrap).
  - tmr_full = (cnt == TC), combinational from cnt.
  - tmr_full rises exactly TC edges after the edge that loaded 0.
- Simultaneous events:
  - clr_tmr at saturation: tmr_full drops after that edge.
  - vld and clr_tmr are independent and act in the same cycle.
- Reset mid-operation: every register returns to its reset value immediately (asynchronous). Partial history is discarded.

Test Plan:
- Reset, then hold clr_tmr low with fast_sim=1 → tmr_full=0 through 32766 clocks, 1 at clock 32767, and stays 1. Pulse clr_tmr → tmr_full=0 the next cycle, then 1 again 32767 clocks later.
- Apply 4 vld strobes of lft=rght=12'h180 → after 4th strobe+1 clock, sum=0x300: sum_gt_min=1, sum_lt_min=0, both diff flags 0. After only the 1st strobe (avg 0x60 each, sum 0xC0): sum_lt_min=1.
- Apply 4 strobes of lft=rght=12'h100 (sum 0x200, in band) → sum_gt_min=0 and sum_lt_min=0. Then 4 strobes of 12'h080 each (sum 0x100) → sum_lt_min=1.
- Apply 4 strobes of lft=0x200, rght=0x140 (sum 832, diff 192) → diff_gt_eigth=1, diff_gt_15_16=0, sum_gt_min=1.
- Apply 4 strobes of lft=0x300, rght=0x010 (sum 784, diff 752 > 735) → diff_gt_15_16=1 and diff_gt_eigth=1. Swap sides → identical flags (absolute difference).
- Assert rst_n low mid-stream after 2 strobes and with the timer mid-count → all outputs at reset values within the same cycle. Post-reset, a single strobe of 0x180 each yields avg 0x60 each, i.e. no leftover history.

Source files
------------

// File: rtl/steer_en_dp.sv
// steer_en_dp: datapath stage feeding the steering-enable state machine.
// Averages the last four left/right load-cell readings, derives registered
// rider-weight and balance flags, and runs the rider-settle timer.
module steer_en_dp #(
  parameter logic        fast_sim         = 1'b0,
  parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
  parameter logic [11:0] HYSTERESIS       = 12'h040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        clr_tmr,
  output logic        tmr_full,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_eigth,
  output logic        diff_gt_15_16
);

  // Settle time: 1.3 s at 50 MHz, or a short count for simulation.
  localparam logic [25:0] TC = fast_sim ? 26'd32767 : 26'd64_999_999;

  // Weight hysteresis band edges, widened to the 13-bit sum width.
  localparam logic [12:0] SUM_HI = 13'(MIN_RIDER_WEIGHT) + 13'(HYSTERESIS);
  localparam logic [12:0] SUM_LO = 13'(MIN_RIDER_WEIGHT) - 13'(HYSTERESIS);

  logic [11:0] lft_hist  [4];
  logic [11:0] rght_hist [4];

  logic [13:0] lft_acc;
  logic [13:0] rght_acc;
  logic [11:0] lft_avg;
  logic [11:0] rght_avg;
  logic [12:0] sum;
  logic [11:0] diff;
  logic        gt_nxt;
  logic        lt_nxt;
  logic        d8_nxt;
  logic        d15_nxt;

  logic [25:0] cnt;

  // Per-side 4-deep reading history, shifted only on a valid strobe.
  // NOTE: the history arrays are reset explicitly so a reset discards any
  // partial history; arrays are not cleared by reset unless written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        lft_hist[i]  <= '0;
        rght_hist[i] <= '0;
      end
    end else if (vld) begin
      // NOTE: non-blocking assignments make every entry shift from its
      // pre-edge value, so the order of these statements does not matter.
      lft_hist[0]  <= lft_ld;
      rght_hist[0] <= rght_ld;
      for (int i = 1; i < 4; i++) begin
        lft_hist[i]  <= lft_hist[i-1];
        rght_hist[i] <= rght_hist[i-1];
      end
    end
  end

  // Moving averages, their sum and absolute difference, and the raw flags.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no
    // latches are inferred.
    lft_acc  = 14'(lft_hist[0])  + 14'(lft_hist[1])  +
               14'(lft_hist[2])  + 14'(lft_hist[3]);
    rght_acc = 14'(rght_hist[0]) + 14'(rght_hist[1]) +
               14'(rght_hist[2]) + 14'(rght_hist[3]);
    lft_avg  = lft_acc[13:2];
    rght_avg = rght_acc[13:2];
    sum      = 13'(lft_avg) + 13'(rght_avg);
    diff     = (lft_avg >= rght_avg) ? (lft_avg - rght_avg)
                                     : (rght_avg - lft_avg);
    gt_nxt   = sum > SUM_HI;
    lt_nxt   = sum < SUM_LO;
    d8_nxt   = 13'(diff) > (sum >> 3);
    d15_nxt  = 13'(diff) > (sum - (sum >> 4));
  end

  // Registered flags, refreshed every clock from the current history;
  // reset values match the result for an all-zero history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_gt_min    <= 1'b0;
      sum_lt_min    <= 1'b1;
      diff_gt_eigth <= 1'b0;
      diff_gt_15_16 <= 1'b0;
    end else begin
      sum_gt_min    <= gt_nxt;
      sum_lt_min    <= lt_nxt;
      diff_gt_eigth <= d8_nxt;
      diff_gt_15_16 <= d15_nxt;
    end
  end

  // Settle timer: clear wins, otherwise count up and saturate at TC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_tmr) begin
      cnt <= '0;
    end else if (cnt < TC) begin
      cnt <= cnt + 26'd1;
    end
  end

  assign tmr_full = (cnt == TC);

endmodule
